// File: rtl/rv32v_uop_sequencer.sv
// Vector micro-op sequencer: expands one decoded vector instruction into one
// micro-op per register of its LMUL group. Outputs are registered and
// handshaked with valid/ready.
module rv32v_uop_sequencer #(
  parameter int unsigned VLEN   = 128,
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned VL_W   = $clog2(VLEN) + 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [4:0]        in_vd,
  input  logic [4:0]        in_vs1,
  input  logic [4:0]        in_vs2,
  input  logic [1:0]        in_vsew,
  input  logic [2:0]        in_vlmul,
  input  logic [VL_W-1:0]   in_vl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_vd,
  output logic [4:0]        out_vs1,
  output logic [4:0]        out_vs2,
  output logic [VL_W-1:0]   out_elem_base,
  output logic [VL_W-1:0]   out_active,
  output logic              out_first,
  output logic              out_last,
  output logic              err
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  // Elements per register at SEW=8; wider SEW just shifts this down.
  localparam logic [VL_W-1:0] Epr8 = VL_W'(VLEN / 8);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [4:0]          vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic [VL_W-1:0]     base_q, base_d, active_q, active_d;
  logic [VL_W-1:0]     vl_q, vl_d, epr_q, epr_d;
  logic [2:0]          idx_q, idx_d, last_idx_q, last_idx_d;
  logic                first_q, first_d, last_q, last_d;
  logic                err_q, err_d;

  logic                accept, illegal, xfer;
  logic [VL_W-1:0]     in_epr, next_base;
  logic [2:0]          in_last_idx;

  // Body elements of a register starting at element 'base', clamped to 0..epr.
  function automatic logic [VL_W-1:0] calc_active(input logic [VL_W-1:0] vl,
                                                    input logic [VL_W-1:0] base,
                                                    input logic [VL_W-1:0] epr);
    logic [VL_W-1:0] rem;
    rem = vl - base;
    if (vl <= base)     return '0;
    else if (rem < epr) return rem;
    else                return epr;
  endfunction

  // Handshake, decode of incoming vsew/vlmul and output wiring.
  always_comb begin
    in_ready  = (state_q == StIdle) && !flush;
    out_valid = (state_q == StIssue);
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
    illegal   = (in_vsew == 2'd3) || (in_vlmul == 3'd4);
    in_epr    = Epr8 >> in_vsew;
    next_base = base_q + epr_q;
    // Fractional LMUL (vlmul[2] set) always uses a single register.
    in_last_idx = 3'd0;
    if (!in_vlmul[2]) begin
      unique case (in_vlmul[1:0])
        2'd0:    in_last_idx = 3'd0;
        2'd1:    in_last_idx = 3'd1;
        2'd2:    in_last_idx = 3'd3;
        default: in_last_idx = 3'd7;
      endcase
    end
    out_ctrl      = ctrl_q;
    out_vd        = vd_q;
    out_vs1       = vs1_q;
    out_vs2       = vs2_q;
    out_elem_base = base_q;
    out_active    = active_q;
    out_first     = first_q;
    out_last      = last_q;
    err           = err_q;
  end

  // Next-state: accept/expand, advance one register per transfer, flush wins.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    vd_d       = vd_q;
    vs1_d      = vs1_q;
    vs2_d      = vs2_q;
    base_d     = base_q;
    active_d   = active_q;
    vl_d       = vl_q;
    epr_d      = epr_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    first_d    = first_q;
    last_d     = last_q;
    err_d      = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            ctrl_d     = in_ctrl;
            vd_d       = in_vd;
            vs1_d      = in_vs1;
            vs2_d      = in_vs2;
            vl_d       = in_vl;
            epr_d      = in_epr;
            idx_d      = 3'd0;
            last_idx_d = in_last_idx;
            base_d     = '0;
            active_d   = calc_active(in_vl, '0, in_epr);
            first_d    = 1'b1;
            last_d     = (in_last_idx == 3'd0);
            if (illegal)               err_d   = 1'b1;
            else if (in_vl != '0)      state_d = StIssue;
          end
        end
        StIssue: begin
          if (xfer) begin
            if (last_q) begin
              state_d = StIdle;
            end else begin
              idx_d    = idx_q + 3'd1;
              vd_d     = vd_q + 5'd1;
              vs1_d    = vs1_q + 5'd1;
              vs2_d    = vs2_q + 5'd1;
              base_d   = next_base;
              active_d = calc_active(vl_q, next_base, epr_q);
              first_d  = 1'b0;
              last_d   = ((idx_q + 3'd1) == last_idx_q);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and field registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      vd_q       <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      base_q     <= '0;
      active_q   <= '0;
      vl_q       <= '0;
      epr_q      <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      vd_q       <= vd_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      base_q     <= base_d;
      active_q   <= active_d;
      vl_q       <= vl_d;
      epr_q      <= epr_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      first_q    <= first_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/rv32v_uop_sequencer.md
Name: rv32v_uop_sequencer

Overview:
- Sits directly downstream of the vector instruction decode stage.
- Accepts one decoded vector instruction at a time and expands it into one micro-op per architectural register of the LMUL register group.
- Each micro-op carries per-register operand indices, element base and active-element count.
- Output feeds the vector issue/execute lanes over a valid/ready handshake.

Parameters:
- VLEN, 128, bits per vector register (power of two, 64..1024)
- CTRL_W, 32, width of opaque decoded control payload replicated onto every micro-op
- VL_W, $clog2(VLEN)+1, width of vl and element-count fields

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- flush  in  1  kill in-flight expansion (pipeline redirect)
- in_valid  in  1  decoded vector instruction present
- in_ready  out  1  sequencer can accept an instruction
- in_ctrl  in  CTRL_W  decoded control payload
- in_vd, in_vs1, in_vs2  in  5 each  base register indices
- in_vsew  in  2  SEW encoding (0=8, 1=16, 2=32, 3=reserved)
- in_vlmul  in  3  LMUL encoding (0..3 = 1,2,4,8; 5..7 = fractional; 4 = reserved)
- in_vl  in  VL_W  current vl
- out_valid  out  1  micro-op present
- out_ready  in  1  downstream accepts micro-op
- out_ctrl  out  CTRL_W  payload copy
- out_vd, out_vs1, out_vs2  out  5 each  base + uop index, mod 32
- out_elem_base  out  VL_W  index of first element in this register
- out_active  out  VL_W  active (body) elements in this register, 0..EPR
- out_first, out_last  out  1 each  first / last micro-op of the instruction
- err  out  1  one-cycle pulse: illegal vsew/vlmul dropped

Behaviour:
- Definitions:
  - EPR = VLEN >> (3 + vsew), elements per register.
  - NREG = 1 << vlmul for vlmul 0..3; NREG = 1 for fractional encodings.
- States: IDLE, ISSUE.
- Reset (nRST low at CLK edge), all outputs and registered fields: state=IDLE, out_valid=0, err=0, uop index=0, out_* data=0.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, latch all in_* fields and uop index i=0.
  - If vsew==3 or vlmul==4: pulse err next cycle and stay in IDLE.
  - Else if vl==0: consume silently (no uops, no err) and stay in IDLE.
  - Else go to ISSUE.
- ISSUE:
  - in_ready=0, out_valid=1 (registered outputs).
  - Register fields: out_vd=vd+i, out_vs1=vs1+i, out_vs2=vs2+i (5-bit wrap, no alignment check).
  - Element fields:
    - out_elem_base = i*EPR.
    - out_active = 0 if vl<=base; vl-base if vl-base<EPR; otherwise EPR.
  - out_first = (i==0); out_last = (i==NREG-1).
  - Micro-ops with out_active=0 (tail registers) are still emitted; tail handling is downstream's job.
- Handshake:
  - A micro-op transfers on out_valid && out_ready.
  - Outputs stay stable while out_valid && !out_ready.
  - On transfer with !out_last: i++ and the next micro-op is presented the following cycle (one uop/cycle sustained).
  - On transfer with out_last: go to IDLE.
  - Result: one bubble cycle between instructions; in_ready is never high in ISSUE.
- Latency: instruction accepted in cycle N → first micro-op valid in cycle N+1.
- flush:
  - Highest priority below reset: state←IDLE, out_valid←0 next cycle.
  - An in_valid in the same cycle as flush is NOT accepted (in_ready forced 0 while flush=1).
  - A micro-op transferring in the flush cycle counts as delivered.
- Arithmetic:
  - out_elem_base and out_active are computed in VL_W bits.
  - Max base = 7*EPR(SEW8) < VLEN, so no overflow.
- err is a single-cycle pulse and never coincides with out_valid.

Test Plan:
- Reset with in_valid=1 held → in_ready=1, out_valid=0, err=0 throughout; nothing latched until nRST=1.
- VLEN=128, vsew=2 (EPR=4), vlmul=2 (NREG=4), vl=10, vd=8, vs2=16, out_ready=1 → 4 uops on consecutive cycles:
  - vd 8,9,10,11; vs2 16..19
  - base 0,4,8,12; active 4,4,2,0
  - first on uop0, last on uop3
  - in_ready returns 1 the next cycle.
- Same instruction with out_ready toggled 1,0,0,1,... → uop fields held stable while stalled; no uop skipped or duplicated; 4 transfers total.
- vsew=3, or vlmul=4 → err pulses exactly one cycle, no out_valid; vl=0 legal instruction → no uops, no err.
- vlmul=7 (fractional), vsew=0, vl=5 → single uop: base 0, active 5, first=last=1. vd=31, vlmul=1 → out_vd 31 then 0 (wrap).
- flush asserted at the second uop of an LMUL=8 instruction → out_valid=0 next cycle, state IDLE, next instruction expands from i=0.
